inv_sbox_engine: RTL and testbench

//  - Applies the AES inverse S-box (InvSubBytes) to a 128-bit AES state, BYTES_PER_CYCLE bytes per clock.
//  - Sits in the GField decrypt datapath, between InvShiftRows and AddRoundKey.
//  - Does not use a 256-entry table. Each byte is computed as inverse affine transform, then GF(2^8) multiplicative inverse.
//  - Has valid/ready handshakes on both the input and output sides.

---
 rtl/gfield_pkg.sv | 43 ++++
 rtl/gf_inv_sbox_byte.sv | 25 ++
 rtl/inv_sbox_engine.sv | 99 +++++++++
 tb/tb_inv_sbox_engine.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfield_pkg.sv
// Shared GF(2^8) definitions for the AES decrypt datapath: field constants,
// state type, engine state encoding and small field-arithmetic helpers.
package gfield_pkg;

    localparam logic [8:0] AES_POLY         = 9'h11B;
    localparam logic [7:0] AES_AFFINE_C     = 8'h63;
    localparam logic [7:0] AES_INV_AFFINE_C = 8'h05;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } eng_state_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY[7:0] : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ t;
            end
            t = gf_xtime(t);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_sq(input logic [7:0] a);
        return gf_mul(a, a);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

endpackage

// File: rtl/gf_inv_sbox_byte.sv
// AES inverse S-box for one byte: inverse affine, then GF(2^8) inverse as x^254.
// Purely combinational (zero latency), no handshake.
module gf_inv_sbox_byte
    import gfield_pkg::*;
(
    input  logic [7:0] x,
    output logic [7:0] y
);

    logic [7:0] a;
    logic [7:0] p3, p7, p15, p31, p63, p127;

    // x^254 = x^-1 for x != 0 and maps 0 to 0, so no special case is needed
    always_comb begin
        a    = rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ AES_INV_AFFINE_C;
        p3   = gf_mul(gf_sq(a), a);
        p7   = gf_mul(gf_sq(p3), a);
        p15  = gf_mul(gf_sq(p7), a);
        p31  = gf_mul(gf_sq(p15), a);
        p63  = gf_mul(gf_sq(p31), a);
        p127 = gf_mul(gf_sq(p63), a);
        y    = gf_sq(p127);
    end

endmodule

// File: rtl/inv_sbox_engine.sv
// InvSubBytes over a 128-bit state, BYTES_PER_CYCLE bytes per clock; result valid 16/BPC clocks after accept.
// in_ready only in IDLE; result held in DONE until out_ready; flush aborts to IDLE with priority.
module inv_sbox_engine
    import gfield_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 1
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_state_t in_data,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output aes_state_t out_data,
    output logic       busy
);

    localparam int N  = 16 / BYTES_PER_CYCLE;
    localparam int SW = 8 * BYTES_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
        $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    eng_state_t             state_q;
    logic [CW-1:0]          cnt_q;
    logic [N-1:0][SW-1:0]   data_q;
    logic [N-1:0][SW-1:0]   data_upd;
    logic [N:0][SW-1:0]     sel_acc;
    logic [N-1:0]           slice_hit;
    logic [SW-1:0]          cur_slice;
    logic [SW-1:0]          new_slice;
    logic                   last_slice;

    // One-hot slice select: AND-OR mux for the read, per-slice replace for the write-back
    assign sel_acc[0] = '0;
    for (genvar s = 0; s < N; s++) begin : g_slice
        assign slice_hit[s]   = (cnt_q == CW'(s));
        assign sel_acc[s+1]   = sel_acc[s] | (slice_hit[s] ? data_q[s] : '0);
        assign data_upd[s]    = slice_hit[s] ? new_slice : data_q[s];
    end
    assign cur_slice = sel_acc[N];

    for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_byte
        gf_inv_sbox_byte u_byte (
            .x (cur_slice[8*j +: 8]),
            .y (new_slice[8*j +: 8])
        );
    end

    assign last_slice = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q  <= in_data;
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    data_q <= data_upd;
                    if (last_slice) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == BUSY);
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_inv_sbox_engine.sv
// Bench for inv_sbox_engine at BYTES_PER_CYCLE=1 and 16, checked against a
// table model built from the forward S-box definition.
module tb_inv_sbox_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_s     [2];
    logic         in_valid_s  [2];
    logic         in_ready_s  [2];
    logic [127:0] in_data_s   [2];
    logic         flush_s     [2];
    logic         out_valid_s [2];
    logic         out_ready_s [2];
    logic [127:0] out_data_s  [2];
    logic         busy_s      [2];

    inv_sbox_engine #(.BYTES_PER_CYCLE(1)) u_bpc1 (
        .clk       (clk),
        .reset     (reset_s[0]),
        .in_valid  (in_valid_s[0]),
        .in_ready  (in_ready_s[0]),
        .in_data   (in_data_s[0]),
        .flush     (flush_s[0]),
        .out_valid (out_valid_s[0]),
        .out_ready (out_ready_s[0]),
        .out_data  (out_data_s[0]),
        .busy      (busy_s[0])
    );

    inv_sbox_engine #(.BYTES_PER_CYCLE(16)) u_bpc16 (
        .clk       (clk),
        .reset     (reset_s[1]),
        .in_valid  (in_valid_s[1]),
        .in_ready  (in_ready_s[1]),
        .in_data   (in_data_s[1]),
        .flush     (flush_s[1]),
        .out_valid (out_valid_s[1]),
        .out_ready (out_ready_s[1]),
        .out_data  (out_data_s[1]),
        .busy      (busy_s[1])
    );

    int checks = 0;
    int errors = 0;
    int cur    = 0;
    int n_lat  = 16;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s bpc_dut=%0d got=%h exp=%h", tag, cur, got, exp);
        end
    endtask

    // Schoolbook polynomial product, then long-division reduction by 0x11B
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ ({8'h00, a} << i);
        end
        for (int i = 15; i >= 8; i--) begin
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [127:0] map_state(input logic [127:0] s, input logic inverse);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[8*k +: 8] = inverse ? inv_tab[s[8*k +: 8]] : fwd_tab[s[8*k +: 8]];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (x != 0 && ref_mul(8'(x), 8'(b)) == 8'h01) inv = 8'(b);
            end
            fwd_tab[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_in_ready"},  128'(in_ready_s[cur]),  128'(1));
        check_eq({tag, "_out_valid"}, 128'(out_valid_s[cur]), 128'(0));
        check_eq({tag, "_busy"},      128'(busy_s[cur]),      128'(0));
    endtask

    task automatic do_reset();
        reset_s[cur]     = 1'b1;
        in_valid_s[cur]  = 1'b0;
        in_data_s[cur]   = '0;
        flush_s[cur]     = 1'b0;
        out_ready_s[cur] = 1'b0;
        tick();
        tick();
        check_idle("reset");
        check_eq("reset_out_data", out_data_s[cur], 128'(0));
        #2 reset_s[cur] = 1'b0;
        tick();
    endtask

    task automatic send(input logic [127:0] d);
        int w;
        w = 0;
        while (!in_ready_s[cur] && w < 50) begin
            tick();
            w++;
        end
        check_eq("in_ready_wait", 128'(in_ready_s[cur]), 128'(1));
        in_valid_s[cur] = 1'b1;
        in_data_s[cur]  = d;
        tick();
        in_valid_s[cur] = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid_s[cur] && lat < 64) begin
            tick();
            lat++;
        end
        check_eq("out_valid_wait", 128'(out_valid_s[cur]), 128'(1));
    endtask

    task automatic take();
        out_ready_s[cur] = 1'b1;
        tick();
        out_ready_s[cur] = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [127:0] d);
        int lat;
        send(d);
        wait_out(lat);
        check_eq(tag, out_data_s[cur], map_state(d, 1'b1));
        take();
    endtask

    task automatic scenario_row0();
        int lat;
        logic [127:0] exp0;
        exp0 = 128'h0f0e0d0c0b0a09080706050403020100;
        send(128'h76abd7fe2b670130c56f6bf27b777c63);
        wait_out(lat);
        check_eq("row0_latency", 128'(lat), 128'(n_lat));
        check_eq("row0_data", out_data_s[cur], exp0);
        take();
        check_idle("row0_after");
    endtask

    task automatic scenario_sweep();
        int lat;
        logic [127:0] d;
        logic [127:0] got;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 16; k++) d[8*k +: 8] = 8'(i * 16 + k);
            send(d);
            wait_out(lat);
            got = out_data_s[cur];
            check_eq("sweep_fwd_roundtrip", map_state(got, 1'b0), d);
            if (i == 0) check_eq("sweep_00_to_52", 128'(got[7:0]), 128'(8'h52));
            if (i == 6) check_eq("sweep_63_to_00", 128'(got[31:24]), 128'(8'h00));
            take();
        end
        for (int r = 0; r < 4; r++) run_one("random_state", rand_state());
    endtask

    task automatic scenario_backpressure();
        int lat;
        logic [127:0] d;
        logic [127:0] d2;
        d  = rand_state();
        d2 = rand_state();
        send(d);
        wait_out(lat);
        in_valid_s[cur] = 1'b1;
        in_data_s[cur]  = d2;
        for (int c = 0; c < 20; c++) begin
            check_eq("bp_data_hold", out_data_s[cur], map_state(d, 1'b1));
            check_eq("bp_in_ready",  128'(in_ready_s[cur]),  128'(0));
            check_eq("bp_out_valid", 128'(out_valid_s[cur]), 128'(1));
            tick();
        end
        out_ready_s[cur] = 1'b1;
        tick();
        out_ready_s[cur] = 1'b0;
        check_eq("bp_release_in_ready",  128'(in_ready_s[cur]),  128'(1));
        check_eq("bp_release_out_valid", 128'(out_valid_s[cur]), 128'(0));
        tick();
        in_valid_s[cur] = 1'b0;
        wait_out(lat);
        check_eq("bp_stalled_input", out_data_s[cur], map_state(d2, 1'b1));
        take();
    endtask

    task automatic scenario_async_reset();
        int k;
        send(rand_state());
        k = (n_lat > 7) ? 7 : 0;
        for (int c = 0; c < k; c++) tick();
        check_eq("abort_busy_before", 128'(busy_s[cur]), 128'(1));
        #3 reset_s[cur] = 1'b1;
        #1;
        check_idle("abort");
        check_eq("abort_out_data", out_data_s[cur], 128'(0));
        #2 reset_s[cur] = 1'b0;
        tick();
        run_one("abort_next_state", rand_state());
    endtask

    task automatic scenario_flush();
        int lat;
        int acc;
        logic [127:0] q [3];
        logic [127:0] res [$];
        send(rand_state());
        wait_out(lat);
        flush_s[cur]     = 1'b1;
        out_ready_s[cur] = 1'b1;
        tick();
        flush_s[cur]     = 1'b0;
        out_ready_s[cur] = 1'b0;
        check_idle("flush_done");

        send(rand_state());
        flush_s[cur] = 1'b1;
        tick();
        flush_s[cur] = 1'b0;
        check_idle("flush_busy");
        for (int c = 0; c < 20; c++) tick();
        check_eq("flush_busy_no_result", 128'(out_valid_s[cur]), 128'(0));

        for (int i = 0; i < 3; i++) q[i] = rand_state();
        acc = 0;
        out_ready_s[cur] = 1'b1;
        in_valid_s[cur]  = 1'b1;
        in_data_s[cur]   = q[0];
        for (int c = 0; c < 200 && res.size() < 3; c++) begin
            logic rdy_before;
            logic vld_before;
            rdy_before = in_ready_s[cur];
            vld_before = in_valid_s[cur];
            if (out_valid_s[cur]) res.push_back(out_data_s[cur]);
            tick();
            if (rdy_before && vld_before) begin
                acc++;
                if (acc >= 3) in_valid_s[cur] = 1'b0;
                else          in_data_s[cur]  = q[acc];
            end
        end
        out_ready_s[cur] = 1'b0;
        in_valid_s[cur]  = 1'b0;
        check_eq("b2b_accepts", 128'(acc), 128'(3));
        check_eq("b2b_results", 128'(res.size()), 128'(3));
        for (int i = 0; i < 3; i++) begin
            check_eq("b2b_data", (i < res.size()) ? res[i] : 128'(0), map_state(q[i], 1'b1));
        end
        for (int c = 0; c < 20; c++) tick();
        check_eq("b2b_no_extra", 128'(out_valid_s[cur]), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog bench did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset_s[d]     = 1'b1;
            in_valid_s[d]  = 1'b0;
            in_data_s[d]   = '0;
            flush_s[d]     = 1'b0;
            out_ready_s[d] = 1'b0;
        end
        build_tables();
        for (int d = 0; d < 2; d++) begin
            cur   = d;
            n_lat = (d == 0) ? 16 : 1;
            do_reset();
            scenario_row0();
            scenario_sweep();
            scenario_backpressure();
            scenario_async_reset();
            scenario_flush();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
